// File: rtl/reset_sequencer_pkg.sv
// Shared state encoding and reset-cause codes for the reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'b00,
    ST_REL_ARB = 2'b01,
    ST_RUN     = 2'b10
  } rseq_state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

endpackage

// File: rtl/reset_sequencer_button_filter.sv
// Pushbutton front end: synchronizer, level debounce and a one-cycle press pulse
// on the accepted 0->1 transition.
module button_filter
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_button,
  output logic o_stable,
  output logic o_press
);

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic                   press_q, press_d;
  logic [CNT_W-1:0]       dcnt_q, dcnt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], i_button};
    stable_d = stable_q;
    press_d  = 1'b0;
    dcnt_d   = '0;
    // Any agreement with the accepted level restarts the hold window.
    if (synced != stable_q) begin
      if (dcnt_q == DEB_TC) begin
        stable_d = synced;
        press_d  = synced;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      dcnt_q   <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      dcnt_q   <= dcnt_d;
    end
  end

  assign o_stable = stable_q;
  assign o_press  = press_q;

endmodule

// File: rtl/reset_sequencer.sv
// Reset front end: merges global, button and software resets and releases the
// arbiter first, then the CPU, while keeping a sticky reset-cause code.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ARB_HOLD        = 16,
  parameter int CPU_DELAY       = 16,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_button,
  input  logic       i_soft_rst,
  output logic       o_rst_arb,
  output logic       o_rst_cpu,
  output logic       o_busy,
  output logic [1:0] o_cause
);

  localparam logic [CNT_W-1:0] ARB_TC = CNT_W'(ARB_HOLD - 1);
  localparam logic [CNT_W-1:0] CPU_TC = CNT_W'(CPU_DELAY - 1);

  rseq_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       cause_q, cause_d;
  logic             rst_arb_q, rst_arb_d;
  logic             rst_cpu_q, rst_cpu_d;
  logic             busy_q, busy_d;
  logic             btn_stable, btn_press, press;

  button_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_button_filter (
    .clk     (clk),
    .rst     (rst),
    .i_button(i_button),
    .o_stable(btn_stable),
    .o_press (btn_press)
  );

  // The pulse only ever coincides with the newly accepted high level.
  assign press = btn_press & btn_stable;

  always_comb begin
    state_d = state_q;
    count_d = count_q + 1'b1;
    cause_d = cause_q;
    unique case (state_q)
      ST_HOLD: begin
        if (press) begin
          count_d = '0;
          cause_d = CAUSE_BTN;
        end else if (count_q == ARB_TC) begin
          state_d = ST_REL_ARB;
          count_d = '0;
        end
      end
      ST_REL_ARB: begin
        if (press) begin
          state_d = ST_HOLD;
          count_d = '0;
          cause_d = CAUSE_BTN;
        end else if (count_q == CPU_TC) begin
          state_d = ST_RUN;
          count_d = '0;
        end
      end
      ST_RUN: begin
        count_d = '0;
        if (press) begin
          state_d = ST_HOLD;
          cause_d = CAUSE_BTN;
        end else if (i_soft_rst) begin
          state_d = ST_HOLD;
          cause_d = CAUSE_SOFT;
        end
      end
      default: begin
        state_d = ST_HOLD;
        count_d = '0;
      end
    endcase
    rst_arb_d = (state_d == ST_HOLD);
    rst_cpu_d = (state_d != ST_RUN);
    busy_d    = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_HOLD;
      count_q   <= '0;
      cause_q   <= CAUSE_POR;
      rst_arb_q <= 1'b1;
      rst_cpu_q <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      cause_q   <= cause_d;
      rst_arb_q <= rst_arb_d;
      rst_cpu_q <= rst_cpu_d;
      busy_q    <= busy_d;
    end
  end

  assign o_rst_arb = rst_arb_q;
  assign o_rst_cpu = rst_cpu_q;
  assign o_busy    = busy_q;
  assign o_cause   = cause_q;

endmodule
